// File: rtl/fxp_seq_divider.sv
// rtl/fxp_seq_divider.sv - sequential signed Q2.14 restoring divider, one quotient bit per clock
// Define DIV_ROUND_EN for one guard-bit iteration and round-half-away-from-zero results.
module fxp_seq_divider #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] num,
   input  logic [DATA_W-1:0] den,
   output logic [DATA_W-1:0] q,
   output logic              valid,
   output logic              busy,
   output logic              div_by_zero,
   output logic              overflow
);

   localparam int MAG_W = DATA_W + 1;
`ifdef DIV_ROUND_EN
   localparam int QW = DATA_W + FRAC_W + 1;
`else
   localparam int QW = DATA_W + FRAC_W;
`endif
   localparam int REM_W = MAG_W + 1;
   localparam int CNT_W = $clog2(QW + 1);
   localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic {IDLE, CALC} state_t;
   state_t state, state_n;

   logic              sign;
   logic [MAG_W-1:0]  den_mag;
   logic [MAG_W-1:0]  rem;
   logic [QW-1:0]     dq;
   logic [CNT_W-1:0]  cnt;

   logic [MAG_W-1:0]  num_ext, den_ext, num_abs, den_abs;
   logic [REM_W-1:0]  rem_sh, rem_nx;
   logic              ge;
   logic [QW-1:0]     dq_nx, mag;
   logic [DATA_W-1:0] q_fin, q_zero;
   logic              ov_fin;
   logic              load, zero_div, finish, last;

   // Magnitudes are one bit wider so that -2.0 (0x8000) becomes +32768.
   always_comb begin
      num_ext = {num[DATA_W-1], num};
      den_ext = {den[DATA_W-1], den};
      num_abs = num_ext[MAG_W-1] ? -num_ext : num_ext;
      den_abs = den_ext[MAG_W-1] ? -den_ext : den_ext;
   end

   // The dividend shares the quotient register: its MSB shifts out as a quotient bit shifts in.
   always_comb begin
      rem_sh = {rem, dq[QW-1]};
      ge     = (rem_sh >= REM_W'(den_mag));
      rem_nx = ge ? (rem_sh - REM_W'(den_mag)) : rem_sh;
      dq_nx  = {dq[QW-2:0], ge};
`ifdef DIV_ROUND_EN
      mag    = (dq_nx >> 1) + QW'(dq_nx[0]);
`else
      mag    = dq_nx;
`endif
   end

   always_comb begin
      q_fin  = mag[DATA_W-1:0];
      ov_fin = 1'b0;
      if (!sign) begin
         if (mag > QW'(POS_MAX)) begin
            q_fin  = POS_MAX;
            ov_fin = 1'b1;
         end
      end else if (mag > QW'(NEG_MAX)) begin
         q_fin  = NEG_MAX;
         ov_fin = 1'b1;
      end else begin
         q_fin  = -mag[DATA_W-1:0];
      end
   end

   always_comb begin
      q_zero = POS_MAX;
      if (num == '0)
         q_zero = '0;
      else if (num[DATA_W-1])
         q_zero = NEG_MAX;
   end

   always_comb begin
      state_n  = state;
      load     = 1'b0;
      zero_div = 1'b0;
      finish   = 1'b0;
      last     = (cnt == CNT_W'(QW - 1));
      case (state)
         IDLE: begin
            if (start) begin
               if (den == '0) begin
                  zero_div = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            if (last) begin
               finish  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   assign busy = (state == CALC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign        <= 1'b0;
         den_mag     <= '0;
         rem         <= '0;
         dq          <= '0;
         cnt         <= '0;
         q           <= '0;
         valid       <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (load) begin
            sign    <= num[DATA_W-1] ^ den[DATA_W-1];
            den_mag <= den_abs;
            rem     <= '0;
            dq      <= QW'(num_abs) << (QW - DATA_W);
            cnt     <= '0;
         end
         if (zero_div) begin
            q           <= q_zero;
            valid       <= 1'b1;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
         end
         if (state == CALC) begin
            rem <= MAG_W'(rem_nx);
            dq  <= dq_nx;
            cnt <= cnt + CNT_W'(1);
         end
         if (finish) begin
            q           <= q_fin;
            overflow    <= ov_fin;
            div_by_zero <= 1'b0;
            valid       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fxp_seq_divider.sv
// tb/tb_fxp_seq_divider.sv - directed self-checking bench for fxp_seq_divider
// Expected rounding results and latency follow DIV_ROUND_EN when it is defined.
module tb_fxp_seq_divider;

`ifdef DIV_ROUND_EN
   localparam int          LAT     = 31;
   localparam logic [15:0] Q_TPOS  = 16'h2AAB;
   localparam logic [15:0] Q_TNEG  = 16'hD555;
`else
   localparam int          LAT     = 30;
   localparam logic [15:0] Q_TPOS  = 16'h2AAA;
   localparam logic [15:0] Q_TNEG  = 16'hD556;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] num, den;
   logic [15:0] q;
   logic        valid, busy, div_by_zero, overflow;

   int checks = 0;
   int errors = 0;

   fxp_seq_divider #(.DATA_W(16), .FRAC_W(14)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num         (num),
      .den         (den),
      .q           (q),
      .valid       (valid),
      .busy        (busy),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [15:0] n, input logic [15:0] d);
      num   = n;
      den   = d;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after the accepting edge until valid; optionally pulses start while busy.
   task automatic wait_valid(output int edges, input int inject_at);
      edges = 0;
      while (valid !== 1'b1 && edges < 100) begin
         if (edges == inject_at) begin
            check_eq("busy_at_inject", busy, 1);
            num   = 16'h4000;
            den   = 16'h2000;
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         edges++;
      end
      if (valid !== 1'b1)
         check_eq("valid_timeout", valid, 1);
   endtask

   task automatic run_div(input string tag, input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] exp_q, input logic exp_ov, input logic exp_dz,
                          input int exp_lat);
      int e;
      issue(n, d);
      wait_valid(e, -1);
      check_eq({tag, "_q"}, q, exp_q);
      check_eq({tag, "_ov"}, overflow, exp_ov);
      check_eq({tag, "_dz"}, div_by_zero, exp_dz);
      check_eq({tag, "_lat"}, e, exp_lat);
      @(posedge clk);
      #1;
      check_eq({tag, "_pulse"}, valid, 0);
      check_eq({tag, "_hold"}, q, exp_q);
   endtask

   initial begin
      int e;
      logic seen;
      rst_n = 1'b0;
      start = 1'b0;
      num   = '0;
      den   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_q", q, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_dz", div_by_zero, 0);
      check_eq("rst_ov", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_div("half",     16'h2000, 16'h4000, 16'h2000, 0, 0, LAT);
      run_div("neg_half", 16'h4000, 16'h8000, 16'hE000, 0, 0, LAT);
      run_div("trunc_p",  16'h4000, 16'h6000, Q_TPOS,   0, 0, LAT);
      run_div("trunc_n",  16'hC000, 16'h6000, Q_TNEG,   0, 0, LAT);
      run_div("sat_pos",  16'h4000, 16'h2000, 16'h7FFF, 1, 0, LAT);
      run_div("neg_two",  16'h8000, 16'h4000, 16'h8000, 0, 0, LAT);
      run_div("sat_mm",   16'h8000, 16'hC000, 16'h7FFF, 1, 0, LAT);

      // Reset at iteration 10 while q/overflow hold a nonzero result.
      issue(16'h2000, 16'h4000);
      repeat (10) @(posedge clk);
      #1;
      check_eq("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_q", q, 0);
      check_eq("mid_rst_valid", valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_ov", overflow, 0);
      check_eq("mid_rst_dz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) seen = 1'b1;
      end
      check_eq("mid_no_valid", seen, 0);
      run_div("post_rst", 16'h2000, 16'h4000, 16'h2000, 0, 0, LAT);

      run_div("dz_pos",  16'h1234, 16'h0000, 16'h7FFF, 0, 1, 0);
      run_div("dz_neg",  16'hF000, 16'h0000, 16'h8000, 0, 1, 0);
      run_div("dz_zero", 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);

      // start while busy must not disturb the division in flight.
      issue(16'h2000, 16'h4000);
      check_eq("ign_busy", busy, 1);
      wait_valid(e, 5);
      check_eq("ign_q", q, 16'h2000);
      check_eq("ign_ov", overflow, 0);
      check_eq("ign_lat", e, LAT);

      // Back-to-back: start during the valid cycle is accepted.
      issue(16'h4000, 16'h6000);
      check_eq("b2b_pulse", valid, 0);
      check_eq("b2b_busy", busy, 1);
      wait_valid(e, -1);
      check_eq("b2b_q", q, Q_TPOS);
      check_eq("b2b_lat", e, LAT);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fxp_seq_divider.md
Name: fxp_seq_divider

Overview:
- Sequential signed fixed-point divider, q = num / den, Q2.14 in and Q2.14 out.
- Computes one quotient bit per clock using a radix-2 restoring algorithm on magnitudes.
- Uses the same start/valid handshake as the team's sequential Booth multiplier, so IIR control logic can drive both units in the same way.
- Used for coefficient normalisation and gain computation in the IIR datapath.

Parameters:
- DATA_W, 16, operand and result width (two's complement).
- FRAC_W, 14, fractional bits of num, den and q.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- num  input  DATA_W  dividend, Q2.14 signed.
- den  input  DATA_W  divisor, Q2.14 signed.
- q  output  DATA_W  quotient, Q2.14 signed; held until the next result.
- valid  output  1  one-cycle pulse when q and the flags are updated.
- busy  output  1  high while a division is in progress.
- div_by_zero  output  1  status of the last result; high when den was 0.
- overflow  output  1  status of the last result; high when the quotient saturated.

Behaviour:
- Reset values: q=0, valid=0, busy=0, div_by_zero=0, overflow=0; FSM in IDLE.
- Reset mid-operation aborts the division immediately; no valid pulse follows.
- FSM has two states, IDLE and CALC.
- Operand capture, on edge E0 with start=1 and state IDLE:
  - latch sign = num[MSB] ^ den[MSB];
  - latch |num| and |den| as DATA_W+1-bit magnitudes, so -2.0 (0x8000) maps to 32768;
  - load the dividend register with |num| << FRAC_W;
  - clear the remainder; set iteration count to 0.
- Zero divisor (den==0 at E0): no CALC. At E0 the block directly registers q and sets valid=1, div_by_zero=1, overflow=0, busy=0:
  - num>0 gives q=0x7FFF;
  - num<0 gives q=0x8000;
  - num==0 gives q=0x0000.
- Normal start: on E0 go to CALC, busy=1.
- CALC iteration, N = DATA_W+FRAC_W = 30 per division:
  - shift the next dividend bit into the remainder;
  - if remainder >= |den|, subtract |den| and shift 1 into the quotient, otherwise shift 0.
- Completion, on the edge of the last iteration (E0+N):
  - take the final magnitude M, combinational including the last bit;
  - positive result: M > 0x7FFF gives q=0x7FFF with overflow=1;
  - negative result: M > 0x8000 gives q=0x8000 with overflow=1; otherwise q = -M;
  - M = 0 gives q=0 regardless of sign;
  - set div_by_zero=0, valid=1; busy=0; state IDLE.
- Latency: valid is high in the cycle after edge E0+30; zero-divisor latency is 1 cycle.
- Rounding: truncation of the magnitude, i.e. toward zero.
- start while busy=1 is ignored; operands are not re-sampled.
- start in the same cycle as valid=1 is accepted (back-to-back operation).
- valid deasserts after one cycle, whether or not a new start arrives.
- q and the flags remain stable until the next valid pulse.

Optional Feature:
- Macro DIV_ROUND_EN.
- Defined:
  - one extra iteration (N+1 = 31 cycles) produces a guard bit G;
  - magnitude = (M_ext >> 1) + G, i.e. round-half-away-from-zero;
  - the saturation checks apply after rounding;
  - zero-divisor behaviour is unchanged.
- Undefined: truncation as described above; latency 30.

Test Plan:
- Reset mid-division: assert rst_n=0 at iteration 10 -> all outputs 0 immediately; no valid after release; a new start works normally.
- Basic divides: num=0x2000, den=0x4000 -> q=0x2000, valid exactly 30 cycles after start, flags 0. Then num=0x4000, den=0x8000 -> q=0xE000.
- Truncation and sign: num=0x4000, den=0x6000 -> q=0x2AAA (DIV_ROUND_EN: 0x2AAB). num=0xC000, den=0x6000 -> q=0xD556 (DIV_ROUND_EN: 0xD555).
- Saturation:
  - num=0x4000, den=0x2000 -> q=0x7FFF, overflow=1;
  - num=0x8000, den=0x4000 -> q=0x8000, overflow=0;
  - num=0x8000, den=0xC000 -> q=0x7FFF, overflow=1.
- Zero divisor: den=0 with num=0x1234 / 0xF000 / 0x0000 -> q=0x7FFF / 0x8000 / 0x0000, div_by_zero=1, valid 1 cycle after start.
- Handshake: start pulses while busy -> ignored, result matches the first operands only. start asserted during the valid cycle -> accepted, second valid exactly 30 cycles later.
